// File: rtl/mmu_dma_mbc_pkg.sv
// Shared types and address map for the banked MMU with OAM DMA.
// Region decode is here so the top and the DMA source select use one definition.
package mmu_pkg;

    typedef enum logic [2:0] {BIOS, ROM0, ROMX, VRAM, XRAM, WRAM, AUX, OPEN} region_t;

    typedef enum logic [1:0] {DMA_IDLE, DMA_READ, DMA_WRITE} dma_state_t;

    localparam logic [15:0] BIOS_LAST     = 16'h00FF;
    localparam logic [15:0] RAM_EN_LAST   = 16'h1FFF;
    localparam logic [15:0] ROM_BANK_LAST = 16'h3FFF;
    localparam logic [15:0] RAM_BANK_LAST = 16'h5FFF;
    localparam logic [15:0] ROMX_BASE     = 16'h4000;
    localparam logic [15:0] VRAM_BASE     = 16'h8000;
    localparam logic [15:0] XRAM_BASE     = 16'hA000;
    localparam logic [15:0] WRAM_BASE     = 16'hC000;
    localparam logic [15:0] AUX_BASE      = 16'hFE00;
    localparam logic [15:0] DMA_REG       = 16'hFF46;
    localparam logic [15:0] BIOS_OFF_REG  = 16'hFF50;
    localparam logic [15:0] HRAM_BASE     = 16'hFF80;

    // Echo RAM (E000-FDFF) decodes as WRAM; OAM, I/O and HRAM all fall into AUX.
    function automatic region_t decode_region(input logic [15:0] addr, input logic bios_on);
        region_t r;
        if (bios_on && addr <= BIOS_LAST)  r = BIOS;
        else if (addr < ROMX_BASE)         r = ROM0;
        else if (addr < VRAM_BASE)         r = ROMX;
        else if (addr < XRAM_BASE)         r = VRAM;
        else if (addr < WRAM_BASE)         r = XRAM;
        else if (addr < AUX_BASE)          r = WRAM;
        else                               r = AUX;
        return r;
    endfunction

endpackage

// File: rtl/mmu_dma_mbc_if.sv
// CPU-side and memory-side bus bundle of the MMU; slave is the MMU view.
interface mmu_dma_mbc_if #(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2
);
    logic [15:0]                 iCpuAddr;
    logic                        iCpuWe;
    logic [7:0]                  iCpuData;
    logic [7:0]                  oCpuData;
    logic                        oDmaBusy;
    logic                        oBiosMapped;
    logic [7:0]                  iBiosData;
    logic [ROM_BANK_BITS+13:0]   oRomAddr;
    logic [7:0]                  iRomData;
    logic [RAM_BANK_BITS+12:0]   oXRamAddr;
    logic                        oXRamWe;
    logic [7:0]                  iXRamData;
    logic [12:0]                 oWramAddr;
    logic                        oWramWe;
    logic [7:0]                  iWramData;
    logic [7:0]                  oXWData;
    logic [7:0]                  oOamAddr;
    logic                        oOamWe;
    logic [7:0]                  oOamData;
    logic [7:0]                  iAuxData;

    modport slave (
        input  iCpuAddr, iCpuWe, iCpuData, iBiosData, iRomData, iXRamData, iWramData, iAuxData,
        output oCpuData, oDmaBusy, oBiosMapped, oRomAddr, oXRamAddr, oXRamWe,
               oWramAddr, oWramWe, oXWData, oOamAddr, oOamWe, oOamData
    );

    modport master (
        output iCpuAddr, iCpuWe, iCpuData, iBiosData, iRomData, iXRamData, iWramData, iAuxData,
        input  oCpuData, oDmaBusy, oBiosMapped, oRomAddr, oXRamAddr, oXRamWe,
               oWramAddr, oWramWe, oXWData, oOamAddr, oOamWe, oOamData
    );
endinterface

// File: rtl/mmu_dma_mbc_oam_dma_engine.sv
// OAM DMA sequencer: alternates a source-read cycle with an OAM-write cycle per byte.
// The source byte arrives during WRITE (1-cycle memories) and is forwarded straight to OAM.
module oam_dma_engine
    import mmu_pkg::*;
#(
    parameter int DMA_LENGTH = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_page,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic [15:0] src_addr,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data
);

    localparam int CW = (DMA_LENGTH > 1) ? $clog2(DMA_LENGTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DMA_LENGTH - 1);

    dma_state_t    state;
    logic [CW-1:0] count;
    logic [7:0]    src_hi;

    // The low byte is the counter alone, so it can never carry into the page.
    assign src_addr = {src_hi, 8'(count)};
    assign oam_addr = 8'(count);
    assign oam_data = rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DMA_IDLE;
            count  <= '0;
            src_hi <= '0;
            busy   <= 1'b0;
            oam_we <= 1'b0;
        end else if (start) begin
            state  <= DMA_READ;
            count  <= '0;
            src_hi <= start_page;
            busy   <= 1'b1;
            oam_we <= 1'b0;
        end else begin
            case (state)
                DMA_READ: begin
                    state  <= DMA_WRITE;
                    oam_we <= 1'b1;
                end
                DMA_WRITE: begin
                    oam_we <= 1'b0;
                    if (count == LAST) begin
                        state <= DMA_IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else begin
                        state <= DMA_READ;
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mmu_dma_mbc.sv
// Address router: MBC1-style banking, boot-ROM overlay latch, registered read mux
// and the OAM DMA engine sharing the ROM/XRAM/WRAM ports.
module mmu_dma_mbc
    import mmu_pkg::*;
#(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2,
    parameter int DMA_LENGTH    = 160
) (
    input  logic         iClock,
    input  logic         iReset,
    mmu_dma_mbc_if.slave bus
);

    logic [ROM_BANK_BITS-1:0] rom_bank;
    logic [RAM_BANK_BITS-1:0] ram_bank;
    logic                     ram_enable;
    logic                     bios_mapped;
    logic                     rd_valid;
    region_t                  rd_region;
    region_t                  rd_next;
    region_t                  wr_region;
    logic                     wr_ok;
    logic                     dma_start;
    logic                     dma_busy;
    logic [15:0]              dma_src;
    logic [7:0]               dma_rd_data;
    logic [15:0]              eff_addr;
    logic [ROM_BANK_BITS-1:0] rom_masked;

    // While DMA owns the bus only HRAM and the DMA register stay writable.
    assign wr_ok      = bus.iCpuWe && (!dma_busy || bus.iCpuAddr >= HRAM_BASE || bus.iCpuAddr == DMA_REG);
    assign dma_start  = wr_ok && (bus.iCpuAddr == DMA_REG);
    assign wr_region  = decode_region(bus.iCpuAddr, 1'b0);
    assign rom_masked = bus.iCpuData[ROM_BANK_BITS-1:0];

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rom_bank    <= ROM_BANK_BITS'(1);
            ram_bank    <= '0;
            ram_enable  <= 1'b0;
            bios_mapped <= 1'b1;
            rd_region   <= OPEN;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid  <= 1'b1;
            rd_region <= rd_next;
            if (wr_ok) begin
                if (bus.iCpuAddr <= RAM_EN_LAST)
                    ram_enable <= (bus.iCpuData[3:0] == 4'hA);
                else if (bus.iCpuAddr <= ROM_BANK_LAST)
                    rom_bank <= (rom_masked == '0) ? ROM_BANK_BITS'(1) : rom_masked;
                else if (bus.iCpuAddr <= RAM_BANK_LAST)
                    ram_bank <= bus.iCpuData[RAM_BANK_BITS-1:0];
                if (bus.iCpuAddr == BIOS_OFF_REG && bus.iCpuData != 8'h00)
                    bios_mapped <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_next = decode_region(bus.iCpuAddr, bios_mapped);
        if (dma_busy && bus.iCpuAddr < HRAM_BASE)
            rd_next = OPEN;
        else if (rd_next == XRAM && !ram_enable)
            rd_next = OPEN;
    end

    always_comb begin
        bus.oCpuData = 8'hFF;
        if (!rd_valid)
            bus.oCpuData = 8'h00;
        else begin
            case (rd_region)
                BIOS:       bus.oCpuData = bus.iBiosData;
                ROM0, ROMX: bus.oCpuData = bus.iRomData;
                XRAM:       bus.oCpuData = bus.iXRamData;
                WRAM:       bus.oCpuData = bus.iWramData;
                VRAM, AUX:  bus.oCpuData = bus.iAuxData;
                default:    bus.oCpuData = 8'hFF;
            endcase
        end
    end

    // The source page stays fixed across a transfer, so its decode also selects the byte in WRITE.
    always_comb begin
        dma_rd_data = 8'hFF;
        case (decode_region({dma_src[15:8], 8'h00}, 1'b0))
            ROM0, ROMX: dma_rd_data = bus.iRomData;
            XRAM:       dma_rd_data = bus.iXRamData;
            WRAM:       dma_rd_data = bus.iWramData;
            default:    dma_rd_data = 8'hFF;
        endcase
    end

    assign eff_addr      = dma_busy ? dma_src : bus.iCpuAddr;
    assign bus.oRomAddr  = (eff_addr[15:14] == 2'b01) ? {rom_bank, eff_addr[13:0]}
                                                       : {{ROM_BANK_BITS{1'b0}}, eff_addr[13:0]};
    assign bus.oXRamAddr = {ram_bank, eff_addr[12:0]};
    assign bus.oWramAddr = eff_addr[12:0];
    assign bus.oXRamWe   = wr_ok && (wr_region == XRAM) && ram_enable;
    assign bus.oWramWe   = wr_ok && (wr_region == WRAM);
    assign bus.oXWData   = bus.iCpuData;
    assign bus.oDmaBusy  = dma_busy;
    assign bus.oBiosMapped = bios_mapped;

    oam_dma_engine #(
        .DMA_LENGTH(DMA_LENGTH)
    ) u_dma (
        .clk        (iClock),
        .rst        (iReset),
        .start      (dma_start),
        .start_page (bus.iCpuData),
        .rd_data    (dma_rd_data),
        .busy       (dma_busy),
        .src_addr   (dma_src),
        .oam_we     (bus.oOamWe),
        .oam_addr   (bus.oOamAddr),
        .oam_data   (bus.oOamData)
    );

endmodule
